// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core widths, branch encodings and EXE_CMD codes
package mips_pkg;

  localparam int DW   = 32;
  localparam int RW   = 5;
  localparam int CMDW = 4;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEZ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JMP  = 2'b11
  } br_type_e;

  localparam logic [CMDW-1:0] EXE_ADD = 4'b0000;
  localparam logic [CMDW-1:0] EXE_SUB = 4'b0010;
  localparam logic [CMDW-1:0] EXE_AND = 4'b0100;
  localparam logic [CMDW-1:0] EXE_OR  = 4'b0101;
  localparam logic [CMDW-1:0] EXE_NOR = 4'b0110;
  localparam logic [CMDW-1:0] EXE_XOR = 4'b0111;
  localparam logic [CMDW-1:0] EXE_SLA = 4'b1000;
  localparam logic [CMDW-1:0] EXE_SRA = 4'b1001;
  localparam logic [CMDW-1:0] EXE_SRL = 4'b1010;

  // True when an ID bundle carries no architectural side effect.
  function automatic logic is_bubble(input logic valid, input logic wb_en,
                                     input logic mem_write, input logic [1:0] br_type);
    return ~valid | ~(wb_en | mem_write | (|br_type));
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - W-bit pipeline register with async active-low reset, enable and clear
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Enable gates clear as well, so a held stage ignores a pending clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? '0 : d;
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID->EX pipeline register; ID_EX_PERF_CNT_EN adds bubble/flush counters
module id_ex_stage_reg #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CMDW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            freeze,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [CMDW-1:0] id_exe_cmd,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_wb_en,
  input  logic            id_is_imm,
  input  logic [1:0]      id_br_type,
  input  logic [DW-1:0]   id_pc,
  input  logic [DW-1:0]   id_val1,
  input  logic [DW-1:0]   id_val2,
  input  logic [DW-1:0]   id_imm,
  input  logic [RW-1:0]   id_dest,
  input  logic [RW-1:0]   id_src1,
  input  logic [RW-1:0]   id_src2,
  output logic            ex_valid,
  output logic [CMDW-1:0] ex_exe_cmd,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_wb_en,
  output logic            ex_is_imm,
  output logic [1:0]      ex_br_type,
  output logic [DW-1:0]   ex_pc,
  output logic [DW-1:0]   ex_val1,
  output logic [DW-1:0]   ex_val2,
  output logic [DW-1:0]   ex_imm,
  output logic [RW-1:0]   ex_dest,
  output logic [RW-1:0]   ex_src1,
  output logic [RW-1:0]   ex_src2,
  output logic [31:0]     bubble_cnt,
  output logic [15:0]     flush_cnt
);

  import mips_pkg::*;

  localparam int CW = 1 + CMDW + 4 + 2;
  localparam int XW = 4 * DW + 3 * RW;

  logic          load_en;
  logic [CW-1:0] ctrl_d;
  logic [CW-1:0] ctrl_q;
  logic [XW-1:0] data_d;
  logic [XW-1:0] data_q;

  assign load_en = ~freeze;

  // An invalid slot must never write state, whatever the decoder left on its controls.
  always_comb begin
    ctrl_d = {id_valid, id_exe_cmd, id_mem_read, id_mem_write, id_wb_en, id_is_imm, id_br_type};
    if (!id_valid) begin
      ctrl_d = {1'b0, id_exe_cmd, 1'b0, 1'b0, 1'b0, id_is_imm, BR_NONE};
    end
  end

  assign data_d = {id_pc, id_val1, id_val2, id_imm, id_dest, id_src1, id_src2};

  pipe_reg #(.W(CW)) u_ctrl_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .clr   (flush),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  pipe_reg #(.W(XW)) u_data_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .clr   (flush),
    .d     (data_d),
    .q     (data_q)
  );

  assign {ex_valid, ex_exe_cmd, ex_mem_read, ex_mem_write, ex_wb_en, ex_is_imm, ex_br_type} = ctrl_q;
  assign {ex_pc, ex_val1, ex_val2, ex_imm, ex_dest, ex_src1, ex_src2} = data_q;

`ifdef ID_EX_PERF_CNT_EN
  logic bubble_in;

  assign bubble_in = flush | is_bubble(id_valid, id_wb_en, id_mem_write, id_br_type);

  // Both counters wrap silently; software takes deltas.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (!freeze) begin
      if (bubble_in) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
      if (flush) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - directed self-checking bench for id_ex_stage_reg
module tb_id_ex_stage_reg;

`ifdef ID_EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        freeze, flush, id_valid, id_mem_read, id_mem_write, id_wb_en, id_is_imm;
  logic [3:0]  id_exe_cmd;
  logic [1:0]  id_br_type;
  logic [31:0] id_pc, id_val1, id_val2, id_imm;
  logic [4:0]  id_dest, id_src1, id_src2;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, ex_is_imm;
  logic [3:0]  ex_exe_cmd;
  logic [1:0]  ex_br_type;
  logic [31:0] ex_pc, ex_val1, ex_val2, ex_imm;
  logic [4:0]  ex_dest, ex_src1, ex_src2;
  logic [31:0] bubble_cnt;
  logic [15:0] flush_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_bubble = 32'd0;
  logic [15:0] exp_flush = 16'd0;
  logic [153:0] ex_all;
  logic [153:0] exp_all;

  assign ex_all = {ex_valid, ex_exe_cmd, ex_mem_read, ex_mem_write, ex_wb_en, ex_is_imm, ex_br_type,
                   ex_pc, ex_val1, ex_val2, ex_imm, ex_dest, ex_src1, ex_src2};

  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_exe_cmd(id_exe_cmd), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_wb_en(id_wb_en), .id_is_imm(id_is_imm), .id_br_type(id_br_type), .id_pc(id_pc),
    .id_val1(id_val1), .id_val2(id_val2), .id_imm(id_imm), .id_dest(id_dest),
    .id_src1(id_src1), .id_src2(id_src2), .ex_valid(ex_valid), .ex_exe_cmd(ex_exe_cmd),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_wb_en(ex_wb_en),
    .ex_is_imm(ex_is_imm), .ex_br_type(ex_br_type), .ex_pc(ex_pc), .ex_val1(ex_val1),
    .ex_val2(ex_val2), .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_src1(ex_src1),
    .ex_src2(ex_src2), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] exp_bc();
    return PERF ? exp_bubble : 32'd0;
  endfunction

  function automatic logic [15:0] exp_fc();
    return PERF ? exp_flush : 16'd0;
  endfunction

  task automatic drive_idle();
    freeze = 0; flush = 0; id_valid = 0; id_exe_cmd = 0; id_mem_read = 0; id_mem_write = 0;
    id_wb_en = 0; id_is_imm = 0; id_br_type = 0; id_pc = 0; id_val1 = 0; id_val2 = 0;
    id_imm = 0; id_dest = 0; id_src1 = 0; id_src2 = 0;
  endtask

  // Advance one edge; expected counters follow the counting rules on the current inputs.
  task automatic tick();
    if (rst_n && !freeze) begin
      if (flush || !id_valid || !(id_wb_en || id_mem_write || id_br_type != 2'b00))
        exp_bubble = exp_bubble + 32'd1;
      if (flush) exp_flush = exp_flush + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    #2 rst_n = 0;
    #1;
    checks++;
    if (ex_all !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", ex_all); end
    checks++;
    if (bubble_cnt !== 32'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counters got %0h/%0h exp 0/0", bubble_cnt, flush_cnt);
    end
    @(negedge clk) rst_n = 1;
    id_valid = 1; id_wb_en = 1; id_exe_cmd = 4'b0000; id_val1 = 32'h1234; id_dest = 5'd9;
    tick();
    checks++;
    if (ex_wb_en !== 1'b1 || ex_val1 !== 32'h1234) begin
      errors++; $display("FAIL pre_reset_load got wb=%0b val1=%0h exp 1/1234", ex_wb_en, ex_val1);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (ex_all !== '0) begin errors++; $display("FAIL midrun_reset got %h exp 0", ex_all); end
    exp_bubble = 0; exp_flush = 0;
    checks++;
    if (bubble_cnt !== 32'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL midrun_reset_cnt got %0h/%0h exp 0/0", bubble_cnt, flush_cnt);
    end
    @(negedge clk) rst_n = 1;
    drive_idle();
  endtask

  task automatic test_load();
    id_exe_cmd = 4'b0010; id_wb_en = 1; id_val1 = 32'd5; id_imm = 32'd7; id_dest = 5'd3;
    id_valid = 1; id_pc = 32'h0000_0040;
    #1;
    checks++;
    if (ex_valid !== 1'b0 || ex_val1 !== 32'd0) begin
      errors++; $display("FAIL comb_path got valid=%0b val1=%0h exp 0/0", ex_valid, ex_val1);
    end
    tick();
    exp_all = {1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
               32'h40, 32'd5, 32'd0, 32'd7, 5'd3, 5'd0, 5'd0};
    checks++;
    if (ex_all !== exp_all) begin errors++; $display("FAIL load_sub got %h exp %h", ex_all, exp_all); end
    drive_idle();
    id_valid = 1; id_mem_write = 1; id_is_imm = 1; id_exe_cmd = 4'b0000; id_pc = 32'h0000_0104;
    id_val1 = 32'h1000; id_val2 = 32'hDEAD_BEEF; id_imm = 32'hFFFF_FFFC; id_src1 = 5'd31;
    id_src2 = 5'd17;
    tick();
    exp_all = {1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00,
               32'h104, 32'h1000, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 5'd0, 5'd31, 5'd17};
    checks++;
    if (ex_all !== exp_all) begin errors++; $display("FAIL load_store got %h exp %h", ex_all, exp_all); end
    drive_idle();
    id_valid = 1; id_br_type = 2'b10; id_exe_cmd = 4'b1010; id_mem_read = 1; id_pc = 32'h200;
    tick();
    checks++;
    if (ex_br_type !== 2'b10 || ex_exe_cmd !== 4'b1010 || ex_mem_read !== 1'b1 || ex_pc !== 32'h200) begin
      errors++; $display("FAIL load_bne got br=%0h cmd=%0h rd=%0b pc=%0h exp 2/a/1/200",
                         ex_br_type, ex_exe_cmd, ex_mem_read, ex_pc);
    end
    checks++;
    if (bubble_cnt !== exp_bc() || flush_cnt !== exp_fc()) begin
      errors++; $display("FAIL load_counters got %0h/%0h exp %0h/%0h", bubble_cnt, flush_cnt, exp_bc(), exp_fc());
    end
  endtask

  task automatic test_flush();
    drive_idle();
    id_valid = 1; id_wb_en = 1; id_mem_write = 1; id_exe_cmd = 4'b0111; id_br_type = 2'b11;
    id_pc = 32'h300; id_val1 = 32'hAAAA; id_val2 = 32'hBBBB; id_imm = 32'hCC; id_dest = 5'd7;
    id_src1 = 5'd1; id_src2 = 5'd2; flush = 1;
    tick();
    checks++;
    if (ex_all !== '0) begin errors++; $display("FAIL flush_bubble got %h exp 0", ex_all); end
    checks++;
    if (flush_cnt !== (PERF ? 16'd1 : 16'd0) || bubble_cnt !== (PERF ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL flush_counters got %0h/%0h exp %0h/%0h", bubble_cnt, flush_cnt, exp_bc(), exp_fc());
    end
    flush = 0;
  endtask

  task automatic test_freeze();
    drive_idle();
    id_valid = 1; id_wb_en = 1; id_exe_cmd = 4'b0100; id_pc = 32'h400; id_val1 = 32'h11;
    id_val2 = 32'h22; id_imm = 32'h33; id_dest = 5'd4; id_src1 = 5'd5; id_src2 = 5'd6;
    tick();
    exp_all = {1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
               32'h400, 32'h11, 32'h22, 32'h33, 5'd4, 5'd5, 5'd6};
    freeze = 1; flush = 1;
    for (int i = 0; i < 3; i++) begin
      id_pc = 32'h500 + i; id_val1 = 32'h99 + i; id_dest = 5'd20 + 5'(i); id_valid = i[0];
      tick();
      checks++;
      if (ex_all !== exp_all) begin errors++; $display("FAIL freeze_hold%0d got %h exp %h", i, ex_all, exp_all); end
      checks++;
      if (bubble_cnt !== exp_bc() || flush_cnt !== exp_fc()) begin
        errors++; $display("FAIL freeze_cnt%0d got %0h/%0h exp %0h/%0h", i, bubble_cnt, flush_cnt, exp_bc(), exp_fc());
      end
    end
    freeze = 0;
    tick();
    checks++;
    if (ex_all !== '0) begin errors++; $display("FAIL unfreeze_flush got %h exp 0", ex_all); end
    checks++;
    if (bubble_cnt !== exp_bc() || flush_cnt !== exp_fc()) begin
      errors++; $display("FAIL unfreeze_cnt got %0h/%0h exp %0h/%0h", bubble_cnt, flush_cnt, exp_bc(), exp_fc());
    end
    flush = 0;
  endtask

  task automatic test_invalid();
    drive_idle();
    id_valid = 0; id_wb_en = 1; id_br_type = 2'b10; id_mem_read = 1; id_mem_write = 1;
    id_exe_cmd = 4'b0101; id_is_imm = 1; id_val1 = 32'h77; id_dest = 5'd12;
    tick();
    exp_all = {1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00,
               32'h0, 32'h77, 32'h0, 32'h0, 5'd12, 5'd0, 5'd0};
    checks++;
    if (ex_all !== exp_all) begin errors++; $display("FAIL invalid_safe got %h exp %h", ex_all, exp_all); end
    checks++;
    if (bubble_cnt !== exp_bc()) begin
      errors++; $display("FAIL invalid_cnt got %0h exp %0h", bubble_cnt, exp_bc());
    end
  endtask

  task automatic test_hazard_bubble();
    drive_idle();
    id_valid = 1; id_pc = 32'h600; id_val1 = 32'h5A; id_src1 = 5'd8;
    tick();
    exp_all = {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
               32'h600, 32'h5A, 32'h0, 32'h0, 5'd0, 5'd8, 5'd0};
    checks++;
    if (ex_all !== exp_all) begin errors++; $display("FAIL hazard_bubble got %h exp %h", ex_all, exp_all); end
    checks++;
    if (bubble_cnt !== exp_bc() || flush_cnt !== exp_fc()) begin
      errors++; $display("FAIL hazard_cnt got %0h/%0h exp %0h/%0h", bubble_cnt, flush_cnt, exp_bc(), exp_fc());
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  cmd_t   [4] = '{4'b0000, 4'b0110, 4'b1001, 4'b0010};
    logic        wb_t    [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        vld_t   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] val_t   [4] = '{32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0F0F};
    logic [4:0]  dst_t   [4] = '{5'd1, 5'd31, 5'd16, 5'd0};
    logic        exp_wb  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      id_exe_cmd = cmd_t[i]; id_wb_en = wb_t[i]; id_valid = vld_t[i];
      id_val1 = val_t[i]; id_dest = dst_t[i];
      tick();
      checks++;
      if (ex_exe_cmd !== cmd_t[i] || ex_wb_en !== exp_wb[i] || ex_valid !== vld_t[i] ||
          ex_val1 !== val_t[i] || ex_dest !== dst_t[i]) begin
        errors++; $display("FAIL b2b%0d got cmd=%0h wb=%0b v=%0b val=%0h dst=%0d exp %0h/%0b/%0b/%0h/%0d",
                           i, ex_exe_cmd, ex_wb_en, ex_valid, ex_val1, ex_dest,
                           cmd_t[i], exp_wb[i], vld_t[i], val_t[i], dst_t[i]);
      end
    end
    checks++;
    if (bubble_cnt !== exp_bc()) begin
      errors++; $display("FAIL b2b_cnt got %0h exp %0h", bubble_cnt, exp_bc());
    end
  endtask

  task automatic test_counters();
    drive_idle();
    flush = 1;
    for (int i = 0; i < 10; i++) tick();
    flush = 0;
    checks++;
    if (bubble_cnt !== exp_bc() || flush_cnt !== exp_fc()) begin
      errors++; $display("FAIL cnt_after10 got %0h/%0h exp %0h/%0h", bubble_cnt, flush_cnt, exp_bc(), exp_fc());
    end
`ifdef ID_EX_PERF_CNT_EN
    @(negedge clk);
    force dut.bubble_cnt = 32'hFFFF_FFFF;
    #1 release dut.bubble_cnt;
    exp_bubble = 32'hFFFF_FFFF;
    id_valid = 0;
    tick();
    checks++;
    if (bubble_cnt !== 32'd0) begin
      errors++; $display("FAIL cnt_wrap got %0h exp 0", bubble_cnt);
    end
`endif
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_load();
    test_flush();
    test_freeze();
    test_invalid();
    test_hazard_bubble();
    test_back_to_back();
    test_counters();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
